double_half_adder: RTL and testbench

//  1-bit full adder built from two cascaded half adders:
//   - HA0 adds a_i + b_i.
//   - HA1 adds the HA0 sum + c_i.
//   - Carry = OR of the two half-adder carries.

---
 rtl/double_half_adder.sv | 79 +++++++
 tb/tb_double_half_adder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_half_adder.sv
// 1-bit full adder built from two cascaded half adders, with registered sum/carry and lookahead p/g.
// Optional saturating carry-event counter enabled by defining DOUBLE_HALF_ADDER_CARRY_CNT_EN.
module double_half_adder #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             c_i,
    output logic             s_o,
    output logic             c_o,
    output logic             p_o,
    output logic             g_o,
    output logic             s_r_o,
    output logic             c_r_o,
    output logic [CNT_W-1:0] carry_cnt_o
);

    // Half adder returning {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0] ha0_s;
    logic [1:0] ha1_s;
    logic       sum_s;
    logic       carry_s;
    logic       s_r;
    logic       c_r;

    // Two cascaded half adders; HA0 doubles as the propagate/generate source.
    always_comb begin
        ha0_s   = half_add(a_i, b_i);
        ha1_s   = half_add(ha0_s[0], c_i);
        sum_s   = ha1_s[0];
        carry_s = ha0_s[1] | ha1_s[1];
    end

    assign s_o   = sum_s;
    assign c_o   = carry_s;
    assign p_o   = ha0_s[0];
    assign g_o   = ha0_s[1];
    assign s_r_o = s_r;
    assign c_r_o = c_r;

    // One-cycle registered copy of sum/carry, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_r <= 1'b0;
            c_r <= 1'b0;
        end else begin
            s_r <= sum_s;
            c_r <= carry_s;
        end
    end

`ifdef DOUBLE_HALF_ADDER_CARRY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Count cycles with carry out high; stick at the maximum rather than wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (carry_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign carry_cnt_o = cnt_r;
`else
    assign carry_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_double_half_adder.sv
// Self-checking bench for double_half_adder: a scoreboard queue holds the expected
// registered outputs and counter value for every clock edge outside reset.
module tb_double_half_adder;

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk_i;
    logic             rst_i;
    logic             a_i;
    logic             b_i;
    logic             c_i;
    logic             s_o;
    logic             c_o;
    logic             p_o;
    logic             g_o;
    logic             s_r_o;
    logic             c_r_o;
    logic [CNT_W-1:0] carry_cnt_o;

    int checks;
    int failures;

    logic [1:0]       exp_q[$];
    logic [CNT_W-1:0] cnt_q[$];
    logic [CNT_W-1:0] cnt_model;

    double_half_adder #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .c_i         (c_i),
        .s_o         (s_o),
        .c_o         (c_o),
        .p_o         (p_o),
        .g_o         (g_o),
        .s_r_o       (s_r_o),
        .c_r_o       (c_r_o),
        .carry_cnt_o (carry_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Apply inputs now and record what the next rising edge must capture.
    task automatic drive_push(input logic a, input logic b, input logic c);
        logic [1:0] total;
        a_i = a;
        b_i = b;
        c_i = c;
        total = {1'b0, a} + {1'b0, b} + {1'b0, c};
        exp_q.push_back(total);
`ifdef DOUBLE_HALF_ADDER_CARRY_CNT_EN
        if (total[1] && (cnt_model != CNT_MAX)) cnt_model = cnt_model + 2'd1;
`endif
        cnt_q.push_back(cnt_model);
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        a_i = 1'b0; b_i = 1'b0; c_i = 1'b0;
        cnt_model = '0;
        #1;
        checks++;
        if ({c_r_o, s_r_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_regs: got %b expected 00", {c_r_o, s_r_o});
        end
        checks++;
        if (carry_cnt_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d expected 0", carry_cnt_o);
        end
    endtask

    task automatic test_comb_sweep;
        logic [1:0] tab [8];
        logic [2:0] code;
        tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            code = 3'(i);
            c_i = code[2]; b_i = code[1]; a_i = code[0];
            #10;
            checks++;
            if ({c_o, s_o} !== tab[i]) begin
                failures++;
                $display("FAIL sweep_%0d: got %b expected %b", i, {c_o, s_o}, tab[i]);
            end
            checks++;
            if ({g_o, p_o} !== {code[1] & code[0], code[1] ^ code[0]}) begin
                failures++;
                $display("FAIL sweep_pg_%0d: got %b expected %b", i, {g_o, p_o},
                         {code[1] & code[0], code[1] ^ code[0]});
            end
            checks++;
            if ({c_r_o, s_r_o} !== 2'b00) begin
                failures++;
                $display("FAIL sweep_in_reset_%0d: got %b expected 00", i, {c_r_o, s_r_o});
            end
        end
    endtask

    task automatic test_pg;
        a_i = 1'b1; b_i = 1'b1; c_i = 1'b0;
        #1;
        checks++;
        if ({p_o, g_o} !== 2'b01) begin
            failures++;
            $display("FAIL pg_11: got p=%b g=%b expected p=0 g=1", p_o, g_o);
        end
        a_i = 1'b1; b_i = 1'b0;
        #1;
        checks++;
        if ({p_o, g_o} !== 2'b10) begin
            failures++;
            $display("FAIL pg_10: got p=%b g=%b expected p=1 g=0", p_o, g_o);
        end
        @(negedge clk_i);
        a_i = 1'b0; b_i = 1'b0; c_i = 1'b0;
        rst_i = 1'b0;
        cnt_model = '0;
        exp_q.delete();
        cnt_q.delete();
    endtask

    task automatic test_latency;
        logic [1:0]       e;
        logic [CNT_W-1:0] ec;
        drive_push(1'b0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        e = exp_q.pop_front(); ec = cnt_q.pop_front();
        checks++;
        if ({c_r_o, s_r_o} !== e) begin
            failures++;
            $display("FAIL latency_zero: got %b expected %b", {c_r_o, s_r_o}, e);
        end
        @(negedge clk_i);
        drive_push(1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if ({c_r_o, s_r_o} !== 2'b00) begin
            failures++;
            $display("FAIL latency_early: got %b expected 00", {c_r_o, s_r_o});
        end
        @(posedge clk_i); #1;
        e = exp_q.pop_front(); ec = cnt_q.pop_front();
        checks++;
        if ({c_r_o, s_r_o} !== e) begin
            failures++;
            $display("FAIL latency_capture: got %b expected %b", {c_r_o, s_r_o}, e);
        end
        checks++;
        if (carry_cnt_o !== ec) begin
            failures++;
            $display("FAIL latency_cnt: got %0d expected %0d", carry_cnt_o, ec);
        end
    endtask

    task automatic test_async_reset;
        logic [1:0]       e;
        logic [CNT_W-1:0] ec;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({c_r_o, s_r_o} !== 2'b00) begin
            failures++;
            $display("FAIL async_assert: got %b expected 00", {c_r_o, s_r_o});
        end
        checks++;
        if ({c_o, s_o} !== 2'b11) begin
            failures++;
            $display("FAIL async_comb_hold: got %b expected 11", {c_o, s_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        cnt_model = '0;
        exp_q.delete();
        cnt_q.delete();
        drive_push(1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if ({c_r_o, s_r_o} !== 2'b00) begin
            failures++;
            $display("FAIL async_release_hold: got %b expected 00", {c_r_o, s_r_o});
        end
        @(posedge clk_i); #1;
        e = exp_q.pop_front(); ec = cnt_q.pop_front();
        checks++;
        if ({c_r_o, s_r_o} !== e) begin
            failures++;
            $display("FAIL async_resume: got %b expected %b", {c_r_o, s_r_o}, e);
        end
        checks++;
        if (carry_cnt_o !== ec) begin
            failures++;
            $display("FAIL async_resume_cnt: got %0d expected %0d", carry_cnt_o, ec);
        end
    endtask

    task automatic test_carry_cnt;
        logic [1:0]       e;
        logic [CNT_W-1:0] ec;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        cnt_model = '0;
        exp_q.delete();
        cnt_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            drive_push(1'b1, 1'b1, 1'b0);
            @(posedge clk_i); #1;
            e = exp_q.pop_front(); ec = cnt_q.pop_front();
            checks++;
            if (carry_cnt_o !== ec) begin
                failures++;
                $display("FAIL carry_cnt_%0d: got %0d expected %0d", i, carry_cnt_o, ec);
            end
            checks++;
            if ({c_r_o, s_r_o} !== e) begin
                failures++;
                $display("FAIL carry_cnt_regs_%0d: got %b expected %b", i, {c_r_o, s_r_o}, e);
            end
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (carry_cnt_o !== 2'd0) begin
            failures++;
            $display("FAIL carry_cnt_reset: got %0d expected 0", carry_cnt_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        cnt_model = '0;
        exp_q.delete();
        cnt_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [1:0]       e;
        logic [CNT_W-1:0] ec;
        logic [2:0]       r;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk_i);
            r = 3'($urandom_range(0, 7));
            drive_push(r[0], r[1], r[2]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front(); ec = cnt_q.pop_front();
            checks++;
            if ({c_r_o, s_r_o} !== e || carry_cnt_o !== ec) begin
                failures++;
                $display("FAIL b2b_%0d: got regs=%b cnt=%0d expected regs=%b cnt=%0d",
                         i, {c_r_o, s_r_o}, carry_cnt_o, e, ec);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_comb_sweep();
        test_pg();
        test_latency();
        test_async_reset();
        test_carry_cnt();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
